pic_ack_sequencer: RTL

Interrupt-acknowledge sequencer and in-service manager for the 8-level programmable interrupt controller. It holds the in-service register (ISR) and the rotating priority pointer, and picks the highest-priority unmasked request that outranks every level in service. It raises `int_req` to the CPU, runs the two-pulse INTA sequence, and drives the 8-bit vector. It also retires in-service levels on automatic, specific or non-specific EOI, and sits between the IRR/IMR registers and the data-bus buffer.

---
 rtl/pic_pkg.sv | 15 +
 rtl/pic_ack_sequencer_if.sv | 34 +++
 rtl/pic_prio_pick.sv | 23 ++
 rtl/pic_ack_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC acknowledge sequencer slice.
package pic_pkg;

    typedef logic [2:0] level_t;

    typedef enum logic [1:0] {IDLE, PEND, ACK1} state_t;

    localparam level_t SPURIOUS_LVL = 3'd7;

    // Rank 0 is the level just above the lowest-priority pointer.
    function automatic level_t prio_rank(input level_t level, input level_t lowest);
        return level_t'(level - lowest - 3'd1);
    endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// Request/acknowledge/EOI bundle between the PIC register file, the CPU side and the sequencer.
interface pic_ack_sequencer_if;
    import pic_pkg::*;

    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] base;
    logic       aeoi;
    logic       rot_aeoi;
    logic       inta;
    logic       eoi_ns;
    logic       eoi_sp;
    level_t     eoi_lvl;
    logic       eoi_rot;
    logic       int_req;
    logic [7:0] isr;
    logic [7:0] irr_clr;
    logic [7:0] vector;
    logic       vector_valid;
    logic       spurious;

    modport master (
        output irr, imr, base, aeoi, rot_aeoi, inta,
        output eoi_ns, eoi_sp, eoi_lvl, eoi_rot,
        input  int_req, isr, irr_clr, vector, vector_valid, spurious
    );

    modport slave (
        input  irr, imr, base, aeoi, rot_aeoi, inta,
        input  eoi_ns, eoi_sp, eoi_lvl, eoi_rot,
        output int_req, isr, irr_clr, vector, vector_valid, spurious
    );

endinterface

// File: rtl/pic_prio_pick.sv
// Rotating-priority picker: highest-priority set bit of req given the lowest-priority pointer.
module pic_prio_pick
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  level_t     lowest,
    output logic       found,
    output level_t     level
);

    // Scan from the lowest rank upward so the highest-priority hit is written last.
    always_comb begin
        found = 1'b0;
        level = '0;
        for (int i = 7; i >= 0; i--) begin
            if (req[level_t'(lowest + level_t'(i) + 3'd1)]) begin
                found = 1'b1;
                level = level_t'(lowest + level_t'(i) + 3'd1);
            end
        end
    end

endmodule

// File: rtl/pic_ack_sequencer.sv
// In-service manager and two-pulse INTA sequencer for the 8-level interrupt controller.
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int NLEV = 8
)
(
    input  logic                clk,
    input  logic                rst,
    pic_ack_sequencer_if.slave  bus
);

    state_t          state, state_n;
    level_t          lowest, lowest_n;
    level_t          lvl, lvl_n;
    logic            spur, spur_n;
    logic            int_req_q, int_req_n;
    logic [NLEV-1:0] isr_q, isr_n;
    logic [NLEV-1:0] irr_clr_q, irr_clr_n;
    logic [7:0]      vector_q, vector_n;
    logic            vector_valid_q, vector_valid_n;
    logic            spurious_q, spurious_n;

    logic [NLEV-1:0] isr_set, aeoi_clr, eoi_clr;
    logic [7:0]      req_masked;
    logic            cand_found, isr_found, qualify;
    level_t          cand_lvl, isr_lvl;

    assign req_masked = bus.irr & ~bus.imr;

    pic_prio_pick u_req_pick (
        .req    (req_masked),
        .lowest (lowest),
        .found  (cand_found),
        .level  (cand_lvl)
    );

    pic_prio_pick u_isr_pick (
        .req    (isr_q),
        .lowest (lowest),
        .found  (isr_found),
        .level  (isr_lvl)
    );

    // A request must strictly outrank everything already in service.
    assign qualify = cand_found &&
                     (!isr_found || (prio_rank(cand_lvl, lowest) < prio_rank(isr_lvl, lowest)));

    always_comb begin
        state_n        = state;
        lowest_n       = lowest;
        lvl_n          = lvl;
        spur_n         = spur;
        int_req_n      = int_req_q;
        irr_clr_n      = '0;
        vector_n       = vector_q;
        vector_valid_n = 1'b0;
        spurious_n     = 1'b0;
        isr_set        = '0;
        aeoi_clr       = '0;
        eoi_clr        = '0;

        case (state)
            IDLE: begin
                int_req_n = qualify;
                if (qualify) begin
                    state_n = PEND;
                end
            end
            PEND: begin
                int_req_n = 1'b1;
                if (bus.inta) begin
                    int_req_n = 1'b0;
                    state_n   = ACK1;
                    if (qualify) begin
                        isr_set[cand_lvl]   = 1'b1;
                        irr_clr_n[cand_lvl] = 1'b1;
                        lvl_n               = cand_lvl;
                        spur_n              = 1'b0;
                    end else begin
                        lvl_n  = SPURIOUS_LVL;
                        spur_n = 1'b1;
                    end
                end
            end
            ACK1: begin
                int_req_n = 1'b0;
                if (bus.inta) begin
                    state_n        = IDLE;
                    vector_n       = {bus.base, lvl};
                    vector_valid_n = 1'b1;
                    spurious_n     = spur;
                    if (bus.aeoi && !spur) begin
                        aeoi_clr[lvl] = 1'b1;
                        if (bus.rot_aeoi) begin
                            lowest_n = lvl;
                        end
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                int_req_n = 1'b0;
            end
        endcase

        // Explicit EOI targets the pre-edge ISR; specific wins over non-specific.
        if (bus.eoi_sp) begin
            eoi_clr[bus.eoi_lvl] = 1'b1;
            if (bus.eoi_rot) begin
                lowest_n = bus.eoi_lvl;
            end
        end else if (bus.eoi_ns && isr_found) begin
            eoi_clr[isr_lvl] = 1'b1;
            if (bus.eoi_rot) begin
                lowest_n = isr_lvl;
            end
        end

        isr_n = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lowest         <= SPURIOUS_LVL;
            lvl            <= '0;
            spur           <= 1'b0;
            int_req_q      <= 1'b0;
            isr_q          <= '0;
            irr_clr_q      <= '0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
            spurious_q     <= 1'b0;
        end else begin
            lowest         <= lowest_n;
            lvl            <= lvl_n;
            spur           <= spur_n;
            int_req_q      <= int_req_n;
            isr_q          <= isr_n;
            irr_clr_q      <= irr_clr_n;
            vector_q       <= vector_n;
            vector_valid_q <= vector_valid_n;
            spurious_q     <= spurious_n;
        end
    end

    assign bus.int_req      = int_req_q;
    assign bus.isr          = isr_q;
    assign bus.irr_clr      = irr_clr_q;
    assign bus.vector       = vector_q;
    assign bus.vector_valid = vector_valid_q;
    assign bus.spurious     = spurious_q;

endmodule
